// File: rtl/mem_arb_pkg.sv
// Shared encodings for the DRAM request arbiter: FSM states, requester ids
// and the cache-line offset width used for write/read hazard detection.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WR_WAIT = 2'd2;
  localparam logic [1:0] ST_RD_WAIT = 2'd3;

  localparam logic [1:0] ID_DCW = 2'd0;
  localparam logic [1:0] ID_DCR = 2'd1;
  localparam logic [1:0] ID_ICR = 2'd2;

  localparam int LINE_LSB = 4;

  // Round-robin successor over the three requester ids.
  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == ID_ICR) ? ID_DCW : id + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter; the pointer holds the last granted id and the
// search starts just after it. force_wr hands the grant to the writer.
module rr_arb3
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       force_wr,
  input  logic       take,
  output logic       gnt_valid,
  output logic [1:0] gnt_id
);

  logic [1:0] last_q, last_d;
  logic [1:0] cand1, cand2;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if/else chain can leave a value held (latch inference).
  always_comb begin
    cand1     = next_id(last_q);
    cand2     = next_id(cand1);
    gnt_valid = |req;
    gnt_id    = ID_DCW;
    if (force_wr && req[ID_DCW]) gnt_id = ID_DCW;
    else if (req[cand1])         gnt_id = cand1;
    else if (req[cand2])         gnt_id = cand2;
    else if (req[last_q])        gnt_id = last_q;
    last_d = (take && gnt_valid) ? gnt_id : last_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= ID_DCW;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Serialises dcache write-back, dcache fill and icache fill onto one DRAM
// channel, one transaction outstanding, with completion routed to the owner.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int TMO_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dcw_req,
  input  logic [AWIDTH-1:0] dcw_addr,
  input  logic [15:0]       dcw_mask,
  input  logic [127:0]      dcw_data,
  output logic              dcw_done,
  input  logic              dcr_req,
  input  logic [AWIDTH-1:0] dcr_addr,
  input  logic              icr_req,
  input  logic [AWIDTH-1:0] icr_addr,
  output logic [127:0]      rd_data,
  output logic              dcr_rvalid,
  output logic              icr_rvalid,
  output logic              dcr_done,
  output logic              icr_done,
  output logic              m_wr_start,
  output logic [AWIDTH-1:0] m_wr_addr,
  output logic [15:0]       m_wr_mask,
  output logic [127:0]      m_wr_data,
  input  logic              m_wr_resp,
  output logic              m_rd_start,
  output logic [AWIDTH-1:0] m_rd_addr,
  input  logic              m_rqfull,
  input  logic [127:0]      m_rd_data,
  input  logic              m_rd_valid,
  input  logic              m_rd_finish,
  input  logic              err_clr,
  output logic              err_timeout,
  output logic              busy
);

  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [1:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_mask_q, wr_mask_d;
  logic [127:0]      wr_data_q, wr_data_d;
  logic [AWIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [127:0]      rd_data_q, rd_data_d;
  logic              dcr_rv_q, dcr_rv_d, icr_rv_q, icr_rv_d;
  logic              dcw_done_q, dcw_done_d, dcr_done_q, dcr_done_d;
  logic              icr_done_q, icr_done_d;

  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       hazard, start_now, rv_pulse, done_pulse, tmo_hit;

  // A pending reader of the line being written back must see the new data.
  assign hazard = dcw_req &&
    ((dcr_req && dcr_addr[AWIDTH-1:LINE_LSB] == dcw_addr[AWIDTH-1:LINE_LSB]) ||
     (icr_req && icr_addr[AWIDTH-1:LINE_LSB] == dcw_addr[AWIDTH-1:LINE_LSB]));

  rr_arb3 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({icr_req, dcr_req, dcw_req}),
    .force_wr  (hazard),
    .take      (state_q == ST_IDLE),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign start_now = (state_q == ST_ISSUE) && !m_rqfull;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wr_addr_d  = wr_addr_q;
    wr_mask_d  = wr_mask_q;
    wr_data_d  = wr_data_q;
    rd_addr_d  = rd_addr_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    err_d      = err_q & ~err_clr;
    rv_pulse   = 1'b0;
    done_pulse = 1'b0;
    tmo_hit    = 1'b0;
    case (state_q)
      ST_IDLE: if (gnt_valid) begin
        owner_d = gnt_id;
        state_d = ST_ISSUE;
        if (gnt_id == ID_DCW) begin
          wr_addr_d = dcw_addr;
          wr_mask_d = dcw_mask;
          wr_data_d = dcw_data;
        end else begin
          rd_addr_d = (gnt_id == ID_DCR) ? dcr_addr : icr_addr;
        end
      end
      ST_ISSUE: if (!m_rqfull) begin
        state_d = (owner_q == ID_DCW) ? ST_WR_WAIT : ST_RD_WAIT;
        cnt_d   = '0;
      end
      ST_WR_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (m_wr_resp) begin
          done_pulse = 1'b1;
          state_d    = ST_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_hit    = 1'b1;
          done_pulse = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (m_rd_valid) begin
          rd_data_d = m_rd_data;
          rv_pulse  = 1'b1;
        end
        if (m_rd_finish) begin
          done_pulse = 1'b1;
          state_d    = ST_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_hit    = 1'b1;
          done_pulse = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_hit) err_d = 1'b1;
    dcw_done_d = done_pulse && (owner_q == ID_DCW);
    dcr_done_d = done_pulse && (owner_q == ID_DCR);
    icr_done_d = done_pulse && (owner_q == ID_ICR);
    dcr_rv_d   = rv_pulse && (owner_q == ID_DCR);
    icr_rv_d   = rv_pulse && (owner_q == ID_ICR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= ID_DCW;
      wr_addr_q  <= '0;
      wr_mask_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      dcr_rv_q   <= 1'b0;
      icr_rv_q   <= 1'b0;
      dcw_done_q <= 1'b0;
      dcr_done_q <= 1'b0;
      icr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wr_addr_q  <= wr_addr_d;
      wr_mask_q  <= wr_mask_d;
      wr_data_q  <= wr_data_d;
      rd_addr_q  <= rd_addr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      dcr_rv_q   <= dcr_rv_d;
      icr_rv_q   <= icr_rv_d;
      dcw_done_q <= dcw_done_d;
      dcr_done_q <= dcr_done_d;
      icr_done_q <= icr_done_d;
    end
  end

  assign m_wr_start  = start_now && (owner_q == ID_DCW);
  assign m_rd_start  = start_now && (owner_q != ID_DCW);
  assign m_wr_addr   = wr_addr_q;
  assign m_wr_mask   = wr_mask_q;
  assign m_wr_data   = wr_data_q;
  assign m_rd_addr   = rd_addr_q;
  assign rd_data     = rd_data_q;
  assign dcr_rvalid  = dcr_rv_q;
  assign icr_rvalid  = icr_rv_q;
  assign dcw_done    = dcw_done_q;
  assign dcr_done    = dcr_done_q;
  assign icr_done    = icr_done_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench: stimulus pushes expected events (kind, payload, cycle),
// a monitor pops and compares every start/rvalid/done the arbiter presents.
module tb_mem_req_arbiter;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dcw_req = 1'b0, dcr_req = 1'b0, icr_req = 1'b0;
  logic [31:0]   dcw_addr = '0, dcr_addr = '0, icr_addr = '0;
  logic [15:0]   dcw_mask = '0;
  logic [127:0]  dcw_data = '0, m_rd_data = '0;
  logic          m_wr_resp = 1'b0, m_rqfull = 1'b0, m_rd_valid = 1'b0;
  logic          m_rd_finish = 1'b0, err_clr = 1'b0;
  logic          dcw_done, dcr_rvalid, icr_rvalid, dcr_done, icr_done;
  logic          m_wr_start, m_rd_start, err_timeout, busy;
  logic [31:0]   m_wr_addr, m_rd_addr;
  logic [15:0]   m_wr_mask;
  logic [127:0]  m_wr_data, rd_data;

  mem_req_arbiter #(.AWIDTH(32), .TMO_W(10)) dut (
    .clk(clk), .rst(rst),
    .dcw_req(dcw_req), .dcw_addr(dcw_addr), .dcw_mask(dcw_mask),
    .dcw_data(dcw_data), .dcw_done(dcw_done),
    .dcr_req(dcr_req), .dcr_addr(dcr_addr),
    .icr_req(icr_req), .icr_addr(icr_addr),
    .rd_data(rd_data), .dcr_rvalid(dcr_rvalid), .icr_rvalid(icr_rvalid),
    .dcr_done(dcr_done), .icr_done(icr_done),
    .m_wr_start(m_wr_start), .m_wr_addr(m_wr_addr), .m_wr_mask(m_wr_mask),
    .m_wr_data(m_wr_data), .m_wr_resp(m_wr_resp),
    .m_rd_start(m_rd_start), .m_rd_addr(m_rd_addr), .m_rqfull(m_rqfull),
    .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid), .m_rd_finish(m_rd_finish),
    .err_clr(err_clr), .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef enum int {EV_WR_START, EV_RD_START, EV_DCR_RV, EV_ICR_RV,
                    EV_DCW_DONE, EV_DCR_DONE, EV_ICR_DONE} ev_e;
  typedef struct {
    ev_e          kind;
    logic [31:0]  addr;
    logic [15:0]  mask;
    logic [127:0] data;
    int           at;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  localparam logic [127:0] D_W  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D_R  = 128'hAAAA_5555_AAAA_5555_1111_2222_3333_4444;
  localparam logic [127:0] D_H  = 128'hC0DE_C0DE_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] D_B1 = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
  localparam logic [127:0] D_B2 = 128'h2222_2222_3333_3333_4444_4444_5555_5555;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_e k, input logic [31:0] a,
                           input logic [15:0] m, input logic [127:0] d,
                           input int at);
    exp_t e;
    e.kind = k; e.addr = a; e.mask = m; e.data = d; e.at = at;
    sb.push_back(e);
  endtask

  task automatic see(input ev_e k, input logic [31:0] a,
                     input logic [15:0] m, input logic [127:0] d);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fails++;
      $display("FAIL unexpected_%s: got event at cycle %0d, want none",
               k.name(), cyc_cnt);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.addr !== a || e.mask !== m || e.data !== d ||
          (e.at >= 0 && e.at != cyc_cnt)) begin
        n_fails++;
        $display("FAIL sb_%s: got %s a=%h m=%h d=%h cyc=%0d, want a=%h m=%h d=%h cyc=%0d",
                 e.kind.name(), k.name(), a, m, d, cyc_cnt, e.addr, e.mask,
                 e.data, e.at);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (m_wr_start) see(EV_WR_START, m_wr_addr, m_wr_mask, m_wr_data);
      if (m_rd_start) see(EV_RD_START, m_rd_addr, '0, '0);
      if (dcr_rvalid) see(EV_DCR_RV, '0, '0, rd_data);
      if (icr_rvalid) see(EV_ICR_RV, '0, '0, rd_data);
      if (dcw_done)   see(EV_DCW_DONE, '0, '0, '0);
      if (dcr_done)   see(EV_DCR_DONE, '0, '0, '0);
      if (icr_done)   see(EV_ICR_DONE, '0, '0, '0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output logic is_wr);
    int n;
    n = 0;
    @(negedge clk);
    while (!(m_wr_start || m_rd_start) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    is_wr = m_wr_start;
    if (n >= 2000) begin
      n_checks++;
      n_fails++;
      $display("FAIL start_wait: got no start in %0d cycles, want one", n);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_strobes"}, {m_wr_start, m_rd_start, dcr_rvalid, icr_rvalid,
                              dcw_done, dcr_done, icr_done}, 0);
    check({tag, "_m_wr_addr"}, m_wr_addr, 0);
    check({tag, "_m_wr_mask"}, m_wr_mask, 0);
    check({tag, "_m_wr_data"}, m_wr_data, 0);
    check({tag, "_m_rd_addr"}, m_rd_addr, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_err"}, err_timeout, 0);
  endtask

  // One full read or write served with valid+finish in the same cycle.
  task automatic serve(input ev_e start_kind, input logic [127:0] beat,
                       input logic drop_all);
    logic w;
    wait_start(w);
    check("start_kind", w, start_kind == EV_WR_START);
    tick();
    if (drop_all) begin
      dcw_req = 1'b0; dcr_req = 1'b0; icr_req = 1'b0;
    end
    if (start_kind == EV_WR_START) begin
      m_wr_resp = 1'b1;
      expect_ev(EV_DCW_DONE, '0, '0, '0, cyc_cnt + 1);
    end else begin
      m_rd_valid = 1'b1; m_rd_finish = 1'b1; m_rd_data = beat;
      expect_ev(start_kind == EV_RD_START && beat[0] ? EV_ICR_RV : EV_DCR_RV,
                '0, '0, beat, cyc_cnt + 1);
      expect_ev(beat[0] ? EV_ICR_DONE : EV_DCR_DONE, '0, '0, '0, cyc_cnt + 1);
    end
    tick();
    m_wr_resp = 1'b0; m_rd_valid = 1'b0; m_rd_finish = 1'b0;
  endtask

  initial begin
    int s;
    ev_e ord_kind [6];
    logic [31:0] ord_addr [6];

    fork
      monitor();
    join_none

    #2 rst = 1'b1;
    repeat (3) tick();
    check_idle_outputs("in_rst");
    rst = 1'b0;
    tick();
    check_idle_outputs("post_rst");

    // Continuous requests on distinct lines; pointer starts at dcw.
    // Reader beats carry bit0 = 1 for icr and 0 for dcr to steer routing.
    dcw_req = 1'b1; dcw_addr = 32'h3000_0000; dcw_mask = 16'hA5A5; dcw_data = D_W;
    dcr_req = 1'b1; dcr_addr = 32'h3000_0100;
    icr_req = 1'b1; icr_addr = 32'h3000_0200;
    ord_kind = '{EV_RD_START, EV_RD_START, EV_WR_START,
                 EV_RD_START, EV_RD_START, EV_WR_START};
    ord_addr = '{32'h3000_0100, 32'h3000_0200, 32'h3000_0000,
                 32'h3000_0100, 32'h3000_0200, 32'h3000_0000};
    for (int i = 0; i < 6; i++) begin
      if (ord_kind[i] == EV_WR_START)
        expect_ev(EV_WR_START, ord_addr[i], 16'hA5A5, D_W, cyc_cnt + 1);
      else
        expect_ev(EV_RD_START, ord_addr[i], '0, '0, cyc_cnt + 1);
      serve(ord_kind[i], {124'(i + 16), (i % 3 == 1) ? 4'h1 : 4'h0}, i == 5);
    end
    repeat (2) tick();

    // Queue full for 5 ISSUE cycles; requester fields change after grant.
    m_rqfull = 1'b1;
    dcw_req = 1'b1; dcw_addr = 32'h4000_0020; dcw_mask = 16'h0F0F; dcw_data = D_R;
    s = cyc_cnt;
    expect_ev(EV_WR_START, 32'h4000_0020, 16'h0F0F, D_R, s + 6);
    tick();
    dcw_req = 1'b0; dcw_addr = 32'hDEAD_BEE0; dcw_mask = '0; dcw_data = ~D_R;
    repeat (4) tick();
    @(negedge clk);
    check("rqfull_busy", busy, 1);
    tick();
    m_rqfull = 1'b0;
    serve(EV_WR_START, '0, 1'b0);
    repeat (2) tick();

    // Same-line write and fill with pointer favouring dcr: write goes first.
    dcw_req = 1'b1; dcw_addr = 32'h2000_0010; dcw_mask = 16'h00F0; dcw_data = D_H;
    dcr_req = 1'b1; dcr_addr = 32'h2000_001C;
    expect_ev(EV_WR_START, 32'h2000_0010, 16'h00F0, D_H, cyc_cnt + 1);
    wait_start(s[0]);
    tick();
    m_wr_resp = 1'b1; dcw_req = 1'b0;
    expect_ev(EV_DCW_DONE, '0, '0, '0, cyc_cnt + 1);
    tick();
    m_wr_resp = 1'b0;
    expect_ev(EV_RD_START, 32'h2000_001C, '0, '0, cyc_cnt + 1);
    serve(EV_RD_START, 128'h5A5A_0000_0000_0000_0000_0000_0000_0000, 1'b1);
    repeat (2) tick();

    // Single dcr fill with two beats, then finish alone.
    dcr_req = 1'b1; dcr_addr = 32'h1000_0040;
    expect_ev(EV_RD_START, 32'h1000_0040, '0, '0, cyc_cnt + 1);
    wait_start(s[0]);
    tick();
    dcr_req = 1'b0; m_rd_valid = 1'b1; m_rd_data = D_B1;
    expect_ev(EV_DCR_RV, '0, '0, D_B1, cyc_cnt + 1);
    tick();
    m_rd_data = D_B2;
    expect_ev(EV_DCR_RV, '0, '0, D_B2, cyc_cnt + 1);
    tick();
    m_rd_valid = 1'b0; m_rd_finish = 1'b1;
    expect_ev(EV_DCR_DONE, '0, '0, '0, cyc_cnt + 1);
    tick();
    m_rd_finish = 1'b0;
    @(negedge clk);
    check("fill_done_idle", busy, 0);
    repeat (2) tick();

    // icr fill never finishes: timeout after 1023 wait cycles.
    icr_req = 1'b1; icr_addr = 32'h0800_0100;
    expect_ev(EV_RD_START, 32'h0800_0100, '0, '0, cyc_cnt + 1);
    wait_start(s[0]);
    s = cyc_cnt;
    expect_ev(EV_ICR_DONE, '0, '0, '0, s + 1024);
    tick();
    icr_req = 1'b0;
    while (cyc_cnt < s + 1023) tick();
    @(negedge clk);
    check("tmo_early_err", err_timeout, 0);
    check("tmo_early_busy", busy, 1);
    tick();
    @(negedge clk);
    check("tmo_err", err_timeout, 1);
    check("tmo_idle", busy, 0);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("err_clr", err_timeout, 0);
    tick();

    // Write timeout coinciding with err_clr: set wins.
    dcw_req = 1'b1; dcw_addr = 32'h5000_0000; dcw_mask = 16'hFFFF; dcw_data = D_W;
    expect_ev(EV_WR_START, 32'h5000_0000, 16'hFFFF, D_W, cyc_cnt + 1);
    wait_start(s[0]);
    s = cyc_cnt;
    expect_ev(EV_DCW_DONE, '0, '0, '0, s + 1024);
    tick();
    dcw_req = 1'b0;
    while (cyc_cnt < s + 1023) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("tmo_set_wins", err_timeout, 1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Reset during RD_WAIT abandons the fill; a late finish is ignored.
    dcr_req = 1'b1; dcr_addr = 32'h6000_0000;
    expect_ev(EV_RD_START, 32'h6000_0000, '0, '0, cyc_cnt + 1);
    wait_start(s[0]);
    tick();
    dcr_req = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    repeat (2) tick();
    rst = 1'b0;
    tick();
    m_rd_finish = 1'b1; m_rd_valid = 1'b1; m_rd_data = D_B1;
    tick();
    m_rd_finish = 1'b0; m_rd_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("late_finish_idle", busy, 0);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
